banked_ram: RTL
===============

# banked_ram

Parametrised, banked synchronous RAM for the Hack memory subsystem, generalising the fixed 16K word store into 2**BANK_W banks of configurable width and depth. Writes are decoded to exactly one bank, reads are registered with a valid strobe, and a built-in clear sequencer zero-fills the whole array after every reset. It sits between the CPU memory port and the data-memory address map, replacing fixed-size RAM stacks.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 14, total word-address width; depth = 2**ADDR_W words
- BANK_W, 2, bank-select width; 2**BANK_W banks of 2**(ADDR_W-BANK_W) words each; legal range 0 <= BANK_W < ADDR_W
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- load  input  1  write enable for the current cycle
- rd_en  input  1  read request for the current cycle
- addres  input  ADDR_W  word address; addres[ADDR_W-1 -: BANK_W] selects bank, low ADDR_W-BANK_W bits select word in bank
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle strobe, data_out updated this cycle
- busy  output  1  high while clear sequencer runs; all requests ignored

## Operation
- FSM states: CLEAR, READY.
- rst sampled low: state <= CLEAR, clear pointer <= 0, data_out <= 0, rd_valid <= 0, busy <= 1. No array write in a reset cycle.
- CLEAR (rst high): each cycle write 0 to array word at clear pointer, pointer increments by 1. On the cycle writing address 2**ADDR_W-1, next state = READY, busy <= 0. Pointer wrap is never reached.
- Reset asserted during CLEAR restarts the sweep at address 0.
- In CLEAR, load and rd_en are ignored; rd_valid stays 0, data_out stays 0.
- READY write: load=1 writes data_in to the addressed word of the selected bank only; all other banks unchanged.
- READY read: rd_en=1 captures bank select and word; next cycle data_out = stored word, rd_valid = 1.
- rd_en=0: rd_valid <= 0, data_out holds last value.
- load and rd_en same cycle, same address: read-first; data_out returns the pre-write contents. Different addresses: both proceed independently.
- Output bank mux driven by the registered bank select, not live addres.
- Reset in READY re-enters CLEAR; array contents are re-zeroed, not preserved.

## Timing
- Clear duration: exactly 2**ADDR_W cycles after the first rst-high edge; busy falls on the edge ending the last clear write.
- First accepted request: cycle in which busy is sampled 0.
- Read latency 1 cycle; throughput one read and one write per cycle.
- Write visible to a read issued the following cycle or later.
- rd_valid asserted exactly one cycle per accepted rd_en; never asserted while busy or in reset.
- All outputs are registers; no combinational path from inputs to outputs.

## Test plan
- Use DATA_W=16, ADDR_W=6, BANK_W=2 (4 banks x 16 words) unless noted.
- Reset/clear: hold rst low 3 cycles, release -> busy=1 for exactly 64 cycles, data_out=0, rd_valid=0 throughout; then read all 64 addresses -> each returns 0x0000.
- Bank isolation: write 0xA5A5 to address 0x05, 0x5A5A to 0x15, 0x1234 to 0x25, 0xFFFF to 0x35 -> reads return each value; addresses 0x06/0x16 still 0x0000.
- Read-first collision: mem[0x3F]=0x00FF; same cycle load=1, rd_en=1, addres=0x3F, data_in=0xBEEF -> next cycle data_out=0x00FF, rd_valid=1; following read returns 0xBEEF.
- Back-to-back reads at 0x00,0x10,0x20,0x30 on consecutive cycles -> rd_valid high 4 consecutive cycles, data in issue order; rd_en drop -> rd_valid=0, data_out holds last value.
- Requests while busy: load=1 addres=0x07 data_in=0x7777 and rd_en=1 during clear -> no rd_valid; after busy falls, read 0x07 -> 0x0000.
- Reset mid-clear: assert rst at clear cycle 30 for 1 cycle -> busy stays high, sweep restarts, busy falls exactly 64 cycles after rst release; repeat with ADDR_W=14, BANK_W=2 -> 16384-cycle clear.

Source files
------------

// File: rtl/banked_ram.sv
// Banked synchronous word store: 2**BANK_W banks, registered reads with a valid
// strobe, and a clear sequencer that zero-fills every word after each reset.
module banked_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addres,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int WORD_W = ADDR_W - BANK_W;
  localparam int NBANKS = 1 << BANK_W;
  localparam int WORDS  = 1 << WORD_W;
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [BSEL_W-1:0]   req_bank, clr_bank, rd_bank_q;
  logic [WORD_W-1:0]   req_word, clr_word;
  logic                last_clear;
  logic                clearing;
  logic                accept_rd, accept_wr;

  logic                wr_any;
  logic [BSEL_W-1:0]   wr_bank;
  logic [WORD_W-1:0]   wr_word;
  logic [DATA_W-1:0]   wr_data;

  logic [NBANKS*DATA_W-1:0] bank_flat;

  // With a single bank there is no select field; bank 0 is implied.
  if (BANK_W > 0) begin : g_bank_sel
    assign req_bank = addres[ADDR_W-1 -: BANK_W];
    assign clr_bank = clr_ptr[ADDR_W-1 -: BANK_W];
  end else begin : g_single_bank
    assign req_bank = '0;
    assign clr_bank = '0;
  end

  assign req_word   = addres[WORD_W-1:0];
  assign clr_word   = clr_ptr[WORD_W-1:0];
  assign last_clear = (clr_ptr == {ADDR_W{1'b1}});
  assign clearing   = rst && (state_q == CLEAR);
  assign accept_rd  = rst && (state_q == READY) && rd_en;
  assign accept_wr  = rst && (state_q == READY) && load;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (last_clear) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= CLEAR;
    else      state_q <= state_d;
  end

  // Single write port shared by the clear sweep and normal writes.
  always_comb begin
    wr_any  = accept_wr;
    wr_bank = req_bank;
    wr_word = req_word;
    wr_data = data_in;
    if (clearing) begin
      wr_any  = 1'b1;
      wr_bank = clr_bank;
      wr_word = clr_word;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_ptr   <= '0;
      busy      <= 1'b1;
      rd_valid  <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      busy     <= (state_d == CLEAR);
      rd_valid <= accept_rd;
      if (accept_rd) rd_bank_q <= req_bank;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] q;
    logic              we, re;

    assign we = wr_any && (wr_bank == BSEL_W'(b));
    assign re = accept_rd && (req_bank == BSEL_W'(b));

    always_ff @(posedge clk) begin
      if (we) mem[wr_word] <= wr_data;
    end

    // Read register samples the array before this edge's write: read-first.
    always_ff @(posedge clk) begin
      if (!rst)    q <= '0;
      else if (re) q <= mem[req_word];
    end

    assign bank_flat[b*DATA_W +: DATA_W] = q;
  end

  // Output mux follows the bank captured with the read, not the live address.
  always_comb begin
    data_out = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (rd_bank_q == BSEL_W'(b)) data_out = bank_flat[b*DATA_W +: DATA_W];
    end
  end

endmodule
